// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-flush / memory-freeze hazard controller that sits beside the ID stage.
// Optional performance counters are enabled with the HAZ_PERF_CNT_EN macro.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              br_taken,
  input  logic              ext_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              stall,
  output logic              hz_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl_unit: LOAD_LAT must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic {IDLE = 1'b0, LU_STALL = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LOAD_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       hit;
  logic       pc_en, ifid_en, flush_req, bubble_req, lu_stall;

  assign hit = idex_memread && (idex_rd != '0) &&
               ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Priority: freeze, then load-use stall, then branch flush, then normal flow.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    flush_req  = 1'b0;
    bubble_req = 1'b0;
    lu_stall   = 1'b0;
    if (ext_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (state == LU_STALL || hit) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      bubble_req = 1'b1;
      lu_stall   = 1'b1;
      if (state == LU_STALL) begin
        // ID/EX already holds the bubble, so the hit input is ignored here
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = IDLE;
      end else if (LOAD_LAT > 1) begin
        state_nxt = LU_STALL;
        cnt_nxt   = CNT_INIT;
      end
    end else if (br_taken) begin
      flush_req = 1'b1;
    end
  end

  // Outputs are held low for as long as reset is asserted.
  assign pc_write    = rst_n & pc_en;
  assign ifid_write  = rst_n & ifid_en;
  assign ifid_flush  = rst_n & flush_req;
  assign idex_bubble = rst_n & bubble_req;
  assign stall       = rst_n & lu_stall;
  assign hz_state    = rst_n & (state == LU_STALL);

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && !(&stall_cycles))     stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush && !(&flush_count)) flush_count  <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus;
// per-cycle expected output vectors go through a scoreboard queue.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idex_memread;
  logic [3:0] idex_rd, ifid_rs, ifid_rt;
  logic       ifid_uses_rt, br_taken, ext_stall;

  logic pw1, iw1, fl1, bb1, st1, hz1;
  logic pw3, iw3, fl3, bb3, st3, hz3;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] sc1, fc1, sc3, fc3, sc2, fc2;
  logic pw2, iw2, fl2, bb2, st2, hz2;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(4), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .br_taken(br_taken), .ext_stall(ext_stall), .pc_write(pw1), .ifid_write(iw1),
    .ifid_flush(fl1), .idex_bubble(bb1), .stall(st1), .hz_state(hz1)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(sc1), .flush_count(fc1)
`endif
  );

  hazard_ctrl_unit #(.REG_AW(4), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .br_taken(br_taken), .ext_stall(ext_stall), .pc_write(pw3), .ifid_write(iw3),
    .ifid_flush(fl3), .idex_bubble(bb3), .stall(st3), .hz_state(hz3)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(sc3), .flush_count(fc3)
`endif
  );

`ifdef HAZ_PERF_CNT_EN
  hazard_ctrl_unit #(.REG_AW(4), .LOAD_LAT(2), .CNT_W(16)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .br_taken(br_taken), .ext_stall(ext_stall), .pc_write(pw2), .ifid_write(iw2),
    .ifid_flush(fl2), .idex_bubble(bb2), .stall(st2), .hz_state(hz2),
    .stall_cycles(sc2), .flush_count(fc2)
  );
`endif

  // {pc_write, ifid_write, ifid_flush, idex_bubble, stall, hz_state}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] STL  = 6'b000110;
  localparam logic [5:0] STS  = 6'b000111;
  localparam logic [5:0] FLU  = 6'b111000;
  localparam logic [5:0] ZRO  = 6'b000000;
  localparam logic [5:0] FRZ  = 6'b000001;

  logic [11:0] outs;
  assign outs = {pw1, iw1, fl1, bb1, st1, hz1, pw3, iw3, fl3, bb3, st3, hz3};

  int checks   = 0;
  int failures = 0;

  logic [16:0] plan_s[$];
  logic [11:0] plan_e[$];
  logic [11:0] exp_q[$];

  // {rst_n, memread, rd, rs, rt, uses_rt, br, ext}
  function automatic logic [16:0] st(input logic r, input logic m, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt,
                                     input logic u, input logic b, input logic x);
    return {r, m, rd, rs, rt, u, b, x};
  endfunction

  task automatic add(input logic [16:0] s, input logic [5:0] e1, input logic [5:0] e3);
    plan_s.push_back(s);
    plan_e.push_back({e1, e3});
  endtask

  task automatic drive(input logic [16:0] s);
    {rst_n, idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt, br_taken, ext_stall} = s;
  endtask

  task automatic test_reset();
    logic [11:0] want;
    add(st(0,1,3,3,0,0,0,0), ZRO, ZRO);
    add(st(0,0,0,0,0,0,1,0), ZRO, ZRO);
    add(st(1,0,0,0,0,0,0,0), NORM, NORM);
    for (int i = 0; plan_s.size() > 0; i++) begin
      drive(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL reset[%0d] got=%b want=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_lat();
    logic [11:0] want;
    add(st(1,1,3,3,0,0,0,0), STL,  STL);
    add(st(1,0,3,3,0,0,0,0), NORM, STS);
    add(st(1,0,3,3,0,0,0,0), NORM, STS);
    add(st(1,0,3,3,0,0,0,0), NORM, NORM);
    for (int i = 0; plan_s.size() > 0; i++) begin
      drive(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL load_lat[%0d] got=%b want=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hit_detect();
    logic [11:0] want;
    add(st(1,1,0,0,0,0,0,0), NORM, NORM);  // rd=0 never hazards
    add(st(1,1,5,2,5,0,0,0), NORM, NORM);  // rt match, rt unused
    add(st(1,1,5,2,5,1,0,0), STL,  STL);   // rt match, rt used
    add(st(1,0,5,2,5,1,0,0), NORM, STS);
    add(st(1,0,5,2,5,1,0,0), NORM, STS);
    add(st(1,0,5,2,5,1,0,0), NORM, NORM);
    for (int i = 0; plan_s.size() > 0; i++) begin
      drive(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL hit_detect[%0d] got=%b want=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [11:0] want;
    add(st(1,0,0,0,0,0,1,0), FLU,  FLU);
    add(st(1,0,0,0,0,0,0,0), NORM, NORM);
    add(st(1,1,4,4,0,0,1,0), STL,  STL);   // hit beats branch
    add(st(1,0,4,4,0,0,1,0), FLU,  STS);   // branch ignored during stall
    add(st(1,0,4,4,0,0,1,0), FLU,  STS);
    add(st(1,0,4,4,0,0,1,0), FLU,  FLU);
    add(st(1,0,0,0,0,0,0,0), NORM, NORM);
    for (int i = 0; plan_s.size() > 0; i++) begin
      drive(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL branch[%0d] got=%b want=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ext_stall();
    logic [11:0] want;
    add(st(1,1,6,6,0,0,0,0), STL,  STL);
    add(st(1,0,6,6,0,0,0,0), NORM, STS);
    add(st(1,0,6,6,0,0,0,1), ZRO,  FRZ);   // freeze mid-stall, cnt held
    add(st(1,0,6,6,0,0,0,1), ZRO,  FRZ);
    add(st(1,0,6,6,0,0,0,0), NORM, STS);
    add(st(1,0,6,6,0,0,0,0), NORM, NORM);
    add(st(1,1,6,6,0,0,1,1), ZRO,  ZRO);   // hit + branch deferred by freeze
    add(st(1,1,6,6,0,0,0,0), STL,  STL);
    add(st(1,0,6,6,0,0,0,0), NORM, STS);
    add(st(1,0,6,6,0,0,0,0), NORM, STS);
    add(st(1,0,6,6,0,0,0,0), NORM, NORM);
    for (int i = 0; plan_s.size() > 0; i++) begin
      drive(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL ext_stall[%0d] got=%b want=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [11:0] want;
    add(st(1,1,2,2,0,0,0,0), STL,  STL);
    add(st(1,0,2,2,0,0,0,0), NORM, STS);
    add(st(0,1,2,2,0,0,0,0), ZRO,  ZRO);
    add(st(1,0,2,2,0,0,0,0), NORM, NORM);
    add(st(1,0,2,2,0,0,0,0), NORM, NORM);
    for (int i = 0; plan_s.size() > 0; i++) begin
      drive(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL reset_mid[%0d] got=%b want=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] want;
    add(st(1,1,9,1,9,1,0,0), STL,  STL);
    add(st(1,1,9,1,9,1,0,0), STL,  STS);
    add(st(1,1,9,1,9,1,0,0), STL,  STS);
    add(st(1,1,9,1,9,1,0,0), STL,  STL);
    add(st(1,1,9,1,9,1,0,0), STL,  STS);
    add(st(1,1,9,1,9,1,0,0), STL,  STS);
    add(st(1,0,9,1,9,1,0,0), NORM, NORM);
    for (int i = 0; plan_s.size() > 0; i++) begin
      drive(plan_s.pop_front());
      exp_q.push_back(plan_e.pop_front());
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (outs !== want) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%b want=%b", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    logic [95:0] cwant;
    logic [95:0] cgot;
    add(st(0,0,0,0,0,0,0,0), ZRO,  ZRO);
    add(st(1,0,0,0,0,0,0,0), NORM, NORM);
    for (int h = 0; h < 2; h++) begin
      add(st(1,1,3,3,0,0,0,0), STL,  STL);
      add(st(1,0,3,3,0,0,0,0), NORM, STS);
      add(st(1,0,3,3,0,0,0,0), NORM, STS);
      add(st(1,0,3,3,0,0,0,0), NORM, NORM);
    end
    add(st(1,0,0,0,0,0,1,0), FLU,  FLU);
    add(st(1,0,0,0,0,0,0,0), NORM, NORM);
    while (plan_s.size() > 0) begin
      drive(plan_s.pop_front());
      void'(plan_e.pop_front());
      @(posedge clk); #1;
    end
    // {sc1, fc1, sc3, fc3, sc2, fc2}
    exp_q.push_back(12'd0);
    void'(exp_q.pop_front());
    cwant = {16'd2, 16'd1, 16'd6, 16'd1, 16'd4, 16'd1};
    @(negedge clk);
    cgot = {sc1, fc1, sc3, fc3, sc2, fc2};
    checks++;
    if (cgot !== cwant) begin
      failures++;
      $display("FAIL perf_counters got=%h want=%h", cgot, cwant);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    drive(st(0,0,0,0,0,0,0,0));
    @(posedge clk); #1;
    test_reset();
    test_load_lat();
    test_hit_detect();
    test_branch();
    test_ext_stall();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised next-generation pipeline hazard controller for the 5-stage core; sits beside the ID stage.
- Detects load-to-use hazards with a configurable number of load stall cycles, using an internal state machine and counter.
- Generates the IF/ID flush for branches taken in ID, and honours a global memory-not-ready freeze.
- Drives the PC, IF/ID and ID/EX pipeline-register controls.

Parameters:
- REG_AW, 4, register-specifier width (16 architectural registers; register 0 hardwired zero).
- LOAD_LAT, 1, stall cycles inserted per load-use hazard; legal range 1..15.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- idex_memread  in  1  ID/EX instruction is a load.
- idex_rd  in  REG_AW  ID/EX destination register.
- ifid_rs  in  REG_AW  IF/ID source register 1.
- ifid_rt  in  REG_AW  IF/ID source register 2.
- ifid_uses_rt  in  1  IF/ID instruction actually reads rt.
- br_taken  in  1  branch in ID resolved taken this cycle.
- ext_stall  in  1  memory system not ready; freeze the whole pipeline.
- pc_write  out  1  PC register write enable.
- ifid_write  out  1  IF/ID register write enable.
- ifid_flush  out  1  IF/ID register clear (insert NOP).
- idex_bubble  out  1  zero ID/EX control signals (insert bubble).
- stall  out  1  load-use stall active this cycle.
- hz_state  out  1  0 = IDLE, 1 = LU_STALL (debug).

Behaviour:
- Hit (combinational): idex_memread & (idex_rd != 0) & ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt))).
- State: FSM {IDLE, LU_STALL} plus a 4-bit down-counter cnt.
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0.
  - All outputs forced 0 while rst_n is low.
  - Reset mid-stall aborts the stall immediately; there is no residual stall after rst_n rises.
- Priority per cycle: ext_stall > load-use stall > br_taken > normal.
- ext_stall = 1:
  - pc_write = ifid_write = 0; ifid_flush = idex_bubble = stall = 0.
  - state and cnt hold.
  - A hit arriving during ext_stall is not acted on until ext_stall drops.
- IDLE with hit:
  - This cycle: stall = 1, pc_write = 0, ifid_write = 0, idex_bubble = 1, ifid_flush = 0.
  - If LOAD_LAT == 1, remain in IDLE.
  - Otherwise next state = LU_STALL with cnt = LOAD_LAT-1.
- LU_STALL:
  - Outputs are the same as an IDLE hit, regardless of the hit input (ID/EX now holds a bubble).
  - cnt decrements each cycle.
  - When cnt == 1, next state = IDLE.
  - Total stall cycles per hazard = LOAD_LAT exactly.
  - The hit is re-evaluated in the first cycle back in IDLE; back-to-back hazards each cost LOAD_LAT cycles.
- IDLE, no hit, br_taken = 1: ifid_flush = 1, pc_write = 1, ifid_write = 1, idex_bubble = 0; one-cycle penalty.
- br_taken during a stall is ignored: the branch is still in IF/ID and upstream re-presents br_taken once its operands resolve.
- Normal (IDLE, no hit, no branch): pc_write = ifid_write = 1, all others 0.
- All outputs are combinational from state, cnt and inputs; there is no output register stage.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined adds two outputs:
  - stall_cycles [CNT_W-1:0]: increments every cycle stall = 1.
  - flush_count [CNT_W-1:0]: increments every cycle ifid_flush = 1.
  - Both saturate at all-ones and reset to 0 on rst_n low.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- LOAD_LAT = 1: idex_memread = 1, idex_rd = 3, ifid_rs = 3.
  - Response: exactly 1 cycle stall = 1, idex_bubble = 1, pc_write = 0; normal on the next cycle.
- LOAD_LAT = 3: same hit held one cycle, then ID/EX inputs go to bubble (memread = 0).
  - Response: stall high 3 consecutive cycles; hz_state = 1 for cycles 2-3; IDLE afterwards.
- idex_rd = 0 with memread = 1 and rs = 0 → no stall.
- rt match with ifid_uses_rt = 0 → no stall.
- rt match with ifid_uses_rt = 1 → stall.
- br_taken = 1 with no hit → ifid_flush = 1 for 1 cycle, pc_write = 1.
- br_taken = 1 together with a hit → stall = 1, ifid_flush = 0.
- LOAD_LAT = 3: ext_stall = 1 for 2 cycles in the middle of LU_STALL → all enables 0 and cnt frozen; total stall cycles still 3.
- LOAD_LAT = 3: rst_n pulsed low during LU_STALL → outputs 0 at once; IDLE and normal on release.
- With HAZ_PERF_CNT_EN: 2 hazards at LOAD_LAT = 2 plus 1 taken branch → stall_cycles = 4, flush_count = 1.
